wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/cpu_pkg.sv | 15 +
 rtl/regfile_core.sv | 33 +++
 rtl/wb_regfile.sv | 64 ++++++
 tb/tb_wb_regfile.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the register-write qualification helper.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_AW-1:0] regno_t;

    // A write only takes effect when enabled and not aimed at the hardwired zero register.
    function automatic logic wr_hit(input logic we, input regno_t rd);
        return we && (rd != REG_ZERO);
    endfunction
endpackage

// File: rtl/regfile_core.sv
// 32x32 register array: two combinational read ports, one write port on the rising edge.
// Reads are zero-latency; writes land at the edge; no backpressure, every write is accepted.
module regfile_core
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db
);

    word_t regs [NREGS];

    // Reset wins over a coincident write, so that write is dropped.
    always_ff @(posedge clk) begin
        if (clrn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit(we, wa)) begin
            regs[wa] <= wd;
        end
    end

    assign da = (ra == REG_ZERO) ? '0 : regs[ra];
    assign db = (rb == REG_ZERO) ? '0 : regs[rb];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: source mux, optional write-through bypass, commit counter.
// Reads and wbdata are zero-latency; commits land at the rising edge; no backpressure.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int BYPASS   = 1,
    parameter int COUNT_EN = 1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        wwreg,
    input  logic        wm2reg,
    input  logic [4:0]  wrd,
    input  logic [31:0] wresult,
    input  logic [31:0] wdataout,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [31:0] wbdata,
    output logic [31:0] wcount
);

    word_t arr_qa;
    word_t arr_qb;
    word_t cnt_q;
    logic  wr_live;

    assign wbdata  = wm2reg ? wdataout : wresult;
    assign wr_live = wr_hit(wwreg, wrd);

    regfile_core u_core (
        .clk  (clk),
        .clrn (clrn),
        .we   (wwreg),
        .wa   (wrd),
        .wd   (wbdata),
        .ra   (rs),
        .rb   (rt),
        .da   (arr_qa),
        .db   (arr_qb)
    );

    // Bypass ignores clrn on purpose: it is a pure forwarding path with no state.
    always_comb begin
        qa = arr_qa;
        qb = arr_qb;
        if (BYPASS != 0 && wr_live) begin
            if (rs == wrd) qa = wbdata;
            if (rt == wrd) qb = wbdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            cnt_q <= '0;
        end else if (COUNT_EN != 0 && wr_live) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign wcount = (COUNT_EN != 0) ? cnt_q : '0;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, counter wrap sequence, random run vs array model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        clrn, wwreg, wm2reg;
    logic [4:0]  wrd, rs, rt;
    logic [31:0] wresult, wdataout;
    logic [31:0] qa1, qb1, wb1, cnt1;
    logic [31:0] qa0, qb0, wb0, cnt0;

    int total = 0;
    int bad   = 0;

    logic [31:0] mreg [32];
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    wb_regfile #(.BYPASS(1), .COUNT_EN(1)) dut1 (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wrd(wrd),
        .wresult(wresult), .wdataout(wdataout), .rs(rs), .rt(rt),
        .qa(qa1), .qb(qb1), .wbdata(wb1), .wcount(cnt1)
    );

    wb_regfile #(.BYPASS(0), .COUNT_EN(0)) dut0 (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wrd(wrd),
        .wresult(wresult), .wdataout(wdataout), .rs(rs), .rt(rt),
        .qa(qa0), .qb(qb0), .wbdata(wb0), .wcount(cnt0)
    );

    typedef struct {
        logic        clrn, wwreg, wm2reg;
        logic [4:0]  wrd, rs, rt;
        logic [31:0] wresult, wdataout;
        logic [31:0] e_qa1, e_qb1, e_qa0, e_qb0, e_wb;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_wb();
        return wm2reg ? wdataout : wresult;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r, input bit byp);
        if (r == 5'd0) return 32'd0;
        if (byp && wwreg && wrd == r) return m_wb();
        return mreg[r];
    endfunction

    task automatic m_edge();
        if (clrn) begin
            for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
            mcnt = 32'd0;
        end else if (wwreg && wrd != 5'd0) begin
            mreg[wrd] = m_wb();
            mcnt = mcnt + 32'd1;
        end
    endtask

    task automatic drive(input logic c, input logic we, input logic m2r, input logic [4:0] d,
                         input logic [31:0] res, input logic [31:0] dout,
                         input logic [4:0] a, input logic [4:0] b);
        clrn = c; wwreg = we; wm2reg = m2r; wrd = d;
        wresult = res; wdataout = dout; rs = a; rt = b;
    endtask

    // One cycle against the model: combinational checks before the edge, counter after it.
    task automatic model_cycle(input string tag);
        @(negedge clk);
        chk({tag, " qa byp"},   qa1, m_read(rs, 1'b1));
        chk({tag, " qb byp"},   qb1, m_read(rt, 1'b1));
        chk({tag, " qa nobyp"}, qa0, m_read(rs, 1'b0));
        chk({tag, " qb nobyp"}, qb0, m_read(rt, 1'b0));
        chk({tag, " wbdata"},   wb1, m_wb());
        @(posedge clk);
        m_edge();
        #1;
        chk({tag, " wcount"},    cnt1, mcnt);
        chk({tag, " wcount off"}, cnt0, 32'd0);
    endtask

    initial begin
        // clrn wwreg m2r wrd rs rt wresult wdataout | qa1 qb1 qa0 qb0 wb | cnt after
        vecs[0] = '{1'b0,1'b1,1'b0,5'd5,5'd5,5'd5,32'h12345678,32'hDEADBEEF,
                    32'h12345678,32'h12345678,32'h0,32'h0,32'h12345678, 32'd1};
        vecs[1] = '{1'b0,1'b0,1'b0,5'd5,5'd5,5'd0,32'h0,32'h0,
                    32'h12345678,32'h0,32'h12345678,32'h0,32'h0, 32'd1};
        vecs[2] = '{1'b0,1'b1,1'b1,5'd0,5'd0,5'd0,32'h0,32'hFFFFFFFF,
                    32'h0,32'h0,32'h0,32'h0,32'hFFFFFFFF, 32'd1};
        vecs[3] = '{1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,32'h0,32'h0,
                    32'h0,32'h0,32'h0,32'h0,32'h0, 32'd1};
        vecs[4] = '{1'b0,1'b1,1'b0,5'd7,5'd7,5'd7,32'h12345678,32'hDEADBEEF,
                    32'h12345678,32'h12345678,32'h0,32'h0,32'h12345678, 32'd2};
        vecs[5] = '{1'b0,1'b0,1'b0,5'd7,5'd7,5'd7,32'h0,32'h0,
                    32'h12345678,32'h12345678,32'h12345678,32'h12345678,32'h0, 32'd2};
        vecs[6] = '{1'b0,1'b1,1'b1,5'd5,5'd5,5'd7,32'h1,32'hCAFEF00D,
                    32'hCAFEF00D,32'h12345678,32'h12345678,32'h12345678,32'hCAFEF00D, 32'd3};
        vecs[7] = '{1'b1,1'b1,1'b0,5'd3,5'd3,5'd5,32'hAAAA5555,32'h0,
                    32'hAAAA5555,32'hCAFEF00D,32'h0,32'hCAFEF00D,32'hAAAA5555, 32'd0};
        vecs[8] = '{1'b0,1'b0,1'b0,5'd3,5'd3,5'd5,32'h0,32'h0,
                    32'h0,32'h0,32'h0,32'h0,32'h0, 32'd0};

        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mcnt = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b0;

        for (int r = 1; r < 32; r++) begin
            rs = 5'(r); rt = 5'(r);
            #1;
            chk("reset qa", qa1, 32'd0);
            chk("reset qb nobyp", qb0, 32'd0);
        end
        chk("reset wcount", cnt1, 32'd0);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].clrn, vecs[i].wwreg, vecs[i].wm2reg, vecs[i].wrd,
                  vecs[i].wresult, vecs[i].wdataout, vecs[i].rs, vecs[i].rt);
            @(negedge clk);
            chk($sformatf("vec%0d qa byp", i),   qa1, vecs[i].e_qa1);
            chk($sformatf("vec%0d qb byp", i),   qb1, vecs[i].e_qb1);
            chk($sformatf("vec%0d qa nobyp", i), qa0, vecs[i].e_qa0);
            chk($sformatf("vec%0d qb nobyp", i), qb0, vecs[i].e_qb0);
            chk($sformatf("vec%0d wbdata", i),   wb0, vecs[i].e_wb);
            @(posedge clk);
            m_edge();
            #1;
            chk($sformatf("vec%0d wcount", i),     cnt1, vecs[i].e_cnt);
            chk($sformatf("vec%0d wcount off", i), cnt0, 32'd0);
        end

        // Counter wrap: preload the count just below the top, then commit twice.
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        force dut1.cnt_q = 32'hFFFFFFFE;
        #1;
        release dut1.cnt_q;
        #1;
        mcnt = 32'hFFFFFFFE;
        chk("wrap preload", cnt1, 32'hFFFFFFFE);
        drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h00000909, 32'h0, 5'd9, 5'd0);
        model_cycle("wrap1");
        chk("wrap top", cnt1, 32'hFFFFFFFF);
        drive(1'b0, 1'b1, 1'b1, 5'd10, 32'h0, 32'h0A0A0A0A, 5'd9, 5'd10);
        model_cycle("wrap2");
        chk("wrap zero", cnt1, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd10);
        #1;
        chk("wrap r9", qa0, 32'h00000909);
        chk("wrap r10", qb0, 32'h0A0A0A0A);

        // Random traffic; small register window so reads often hit recent writes.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 7)), $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            model_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
